// File: rtl/sp_ram_responder.sv
// sp_ram_responder
//   Memory-side endpoint of the sp_ram_intf bus. It holds DEPTH words and
//   serves compute reads and byte-masked writes. A host preload port shares
//   the single write port, and compute traffic always wins that port. The
//   block also keeps saturating access counters and a sticky out-of-range flag.
//
//   Read timing: the request (cs=1, oe=1, W_req=0) is sampled on an edge.
//   With READ_LAT=1, o_mem_r_data carries the word right after that edge.
//   With READ_LAT=2, it carries the word one edge later. In both cases the
//   word appears READ_LAT cycles after the request was driven.
//
// Ports
//   clk, rst                 clock (rising edge); asynchronous active-high reset
//   i_mem_cs / i_mem_oe      chip select / output enable from the switcher
//   i_mem_addr               word address
//   i_mem_w_req              per-byte write enable
//   i_mem_w_data             write data
//   o_mem_r_data             registered read data; holds between reads
//   i_ld_valid / o_ld_ready  host load handshake (ready = ~cs)
//   i_ld_addr / i_ld_data    host load address / full-word data
//   o_rd_cnt / o_wr_cnt      saturating read / write(+load) counters
//   o_oob_err / i_err_clr    sticky out-of-range flag / its synchronous clear
module sp_ram_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int READ_LAT   = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_mem_cs,
    input  logic                    i_mem_oe,
    input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
    input  logic [DATA_WIDTH/8-1:0] i_mem_w_req,
    input  logic [DATA_WIDTH-1:0]   i_mem_w_data,
    output logic [DATA_WIDTH-1:0]   o_mem_r_data,
    input  logic                    i_ld_valid,
    output logic                    o_ld_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ld_addr,
    input  logic [DATA_WIDTH-1:0]   i_ld_data,
    output logic [CNT_WIDTH-1:0]    o_rd_cnt,
    output logic [CNT_WIDTH-1:0]    o_wr_cnt,
    output logic                    o_oob_err,
    input  logic                    i_err_clr
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
        $error("sp_ram_responder: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_WIDTH-1:0]  r_rd_cnt, r_wr_cnt;
    logic                  r_oob;

    logic                  w_mem_inr, w_ld_inr;
    logic                  w_rd_issue, w_cwr, w_ld_go, w_oob;
    logic [IDX_W-1:0]      w_mem_idx, w_wr_idx;
    logic [NB-1:0]         w_wr_be;
    logic [DATA_WIDTH-1:0] w_wr_data, w_rd_word;

    assign w_mem_inr  = {1'b0, i_mem_addr} < DEPTH_W;
    assign w_ld_inr   = {1'b0, i_ld_addr} < DEPTH_W;
    assign w_mem_idx  = i_mem_addr[IDX_W-1:0];

    assign w_cwr      = i_mem_cs & (|i_mem_w_req);
    assign w_rd_issue = i_mem_cs & i_mem_oe & ~(|i_mem_w_req);
    assign o_ld_ready = ~i_mem_cs;
    assign w_ld_go    = i_ld_valid & ~i_mem_cs;

    // A read samples the array after any write from the previous edge has
    // landed, so read-after-write needs no bypass path.
    assign w_rd_word  = w_mem_inr ? r_mem[w_mem_idx] : '0;

    // The compute write and the host load are mutually exclusive because
    // ld_ready is ~cs. They share one write port. Out-of-range writes get an
    // all-zero byte mask, so they are dropped.
    always_comb begin
        w_wr_be   = '0;
        w_wr_idx  = w_mem_idx;
        w_wr_data = i_mem_w_data;
        if (w_cwr) begin
            if (w_mem_inr) w_wr_be = i_mem_w_req;
        end else if (w_ld_go) begin
            w_wr_idx  = i_ld_addr[IDX_W-1:0];
            w_wr_data = i_ld_data;
            if (w_ld_inr) w_wr_be = '1;
        end
    end

    // The array is not reset, and it keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++)
                if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    // Read pipeline. Reset clears the valid bits and R_data together, so a
    // read that is in flight during reset is never delivered.
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_rdata <= '0;
            else if (w_rd_issue) r_rdata <= w_rd_word;
        end
    end else if (READ_LAT == 2) begin : g_lat2
        logic [1:1]            r_vld_pipe;
        logic [DATA_WIDTH-1:0] r_pdata;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld_pipe <= '0;
                r_pdata    <= '0;
                r_rdata    <= '0;
            end else begin
                r_vld_pipe[1] <= w_rd_issue;
                if (w_rd_issue)    r_pdata <= w_rd_word;
                if (r_vld_pipe[1]) r_rdata <= r_pdata;
            end
        end
    end else begin : g_bad_lat
        $error("sp_ram_responder: READ_LAT must be 1 or 2");
    end

    // If an access is out of range in the same cycle as err_clr, the set wins.
    assign w_oob = ((w_rd_issue | w_cwr) & ~w_mem_inr) | (w_ld_go & ~w_ld_inr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_oob    <= 1'b0;
        end else begin
            if (w_rd_issue && (r_rd_cnt != '1))
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            if ((w_cwr || w_ld_go) && (r_wr_cnt != '1))
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            if (w_oob)          r_oob <= 1'b1;
            else if (i_err_clr) r_oob <= 1'b0;
        end
    end

    assign o_mem_r_data = r_rdata;
    assign o_rd_cnt     = r_rd_cnt;
    assign o_wr_cnt     = r_wr_cnt;
    assign o_oob_err    = r_oob;
endmodule

// File: tb/tb_sp_ram_responder.sv
// tb_sp_ram_responder
//   Directed bench. Two responders (READ_LAT=1 and READ_LAT=2) share one
//   stimulus stream, so every sequence checks both latencies. Inputs change
//   1ns after a rising edge, and outputs are sampled there as well.
module tb_sp_ram_responder;
    localparam int AW = 16, DW = 32, CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs, oe, ld_valid, err_clr;
    logic [AW-1:0] addr, ld_addr;
    logic [3:0]    w_req;
    logic [DW-1:0] w_data, ld_data;

    logic [DW-1:0] r1_rdata, r2_rdata;
    logic          r1_ready, r2_ready, r1_oob, r2_oob;
    logic [CW-1:0] r1_rd, r1_wr, r2_rd, r2_wr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sp_ram_responder #(.READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .i_mem_cs(cs), .i_mem_oe(oe), .i_mem_addr(addr),
        .i_mem_w_req(w_req), .i_mem_w_data(w_data), .o_mem_r_data(r1_rdata),
        .i_ld_valid(ld_valid), .o_ld_ready(r1_ready), .i_ld_addr(ld_addr),
        .i_ld_data(ld_data), .o_rd_cnt(r1_rd), .o_wr_cnt(r1_wr),
        .o_oob_err(r1_oob), .i_err_clr(err_clr));

    sp_ram_responder #(.READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .i_mem_cs(cs), .i_mem_oe(oe), .i_mem_addr(addr),
        .i_mem_w_req(w_req), .i_mem_w_data(w_data), .o_mem_r_data(r2_rdata),
        .i_ld_valid(ld_valid), .o_ld_ready(r2_ready), .i_ld_addr(ld_addr),
        .i_ld_data(ld_data), .o_rd_cnt(r2_rd), .o_wr_cnt(r2_wr),
        .o_oob_err(r2_oob), .i_err_clr(err_clr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 0; oe = 0; w_req = 4'h0; addr = '0; w_data = '0;
        ld_valid = 0; ld_addr = '0; ld_data = '0; err_clr = 0;
    endtask

    task automatic mwr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        cs = 1; oe = 0; addr = a; w_data = d; w_req = be;
    endtask

    task automatic mrd(input logic [AW-1:0] a);
        cs = 1; oe = 1; addr = a; w_req = 4'h0;
    endtask

    task automatic cnts(input string tag, input int rd, input int wr);
        chk({tag, ".rd1"}, r1_rd, rd);
        chk({tag, ".wr1"}, r1_wr, wr);
        chk({tag, ".rd2"}, r2_rd, rd);
        chk({tag, ".wr2"}, r2_wr, wr);
    endtask

    localparam logic [DW-1:0] LD_DAT [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        idle();
        cyc(3);
        rst = 0;
        cyc(5);
        chk("rst.rdata1", r1_rdata, 0);
        chk("rst.rdata2", r2_rdata, 0);
        chk("rst.oob1", r1_oob, 0);
        chk("rst.oob2", r2_oob, 0);
        chk("rst.ready1", r1_ready, 1);
        chk("rst.ready2", r2_ready, 1);
        cnts("rst", 0, 0);

        // Full-word write, byte-0 overwrite, then read at exact latency.
        mwr(16'h0010, 32'hDEADBEEF, 4'hF); cyc();
        mwr(16'h0010, 32'h000000AA, 4'h1); cyc();
        mrd(16'h0010); cyc();
        chk("be.lat1", r1_rdata, 32'hDEADBEAA);
        chk("be.lat2_early", r2_rdata, 0);
        idle(); cyc();
        chk("be.lat2", r2_rdata, 32'hDEADBEAA);
        chk("be.hold1", r1_rdata, 32'hDEADBEAA);
        cnts("be", 1, 2);

        // Host loads while idle; R_data must be left alone.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_addr = AW'(i); ld_data = LD_DAT[i];
            #1 chk("ld.ready", r1_ready, 1);
            cyc();
        end
        idle(); cyc();
        chk("ld.keep1", r1_rdata, 32'hDEADBEAA);
        chk("ld.keep2", r2_rdata, 32'hDEADBEAA);
        cnts("ld", 1, 6);

        // Back-to-back reads: one result per cycle on both instances.
        for (int i = 0; i < 4; i++) begin
            mrd(AW'(i)); cyc();
            chk("b2b.lat1", r1_rdata, LD_DAT[i]);
            if (i > 0) chk("b2b.lat2", r2_rdata, LD_DAT[i-1]);
        end
        idle(); cyc();
        chk("b2b.lat2_last", r2_rdata, 32'h44);
        cyc(3);
        chk("b2b.hold1", r1_rdata, 32'h44);
        chk("b2b.hold2", r2_rdata, 32'h44);
        cnts("b2b", 5, 6);

        // Host load stalled by three compute writes.
        ld_valid = 1; ld_addr = 16'h0020; ld_data = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            mwr(AW'(16'h30 + i), 32'h0, 4'hF);
            #1 chk("stall.ready1", r1_ready, 0);
            chk("stall.ready2", r2_ready, 0);
            cyc();
        end
        cs = 0; w_req = 4'h0;
        #1 chk("stall.ready_rel", r1_ready, 1);
        cyc();
        idle();
        cnts("stall", 5, 10);
        mrd(16'h0020); cyc();
        chk("stall.data1", r1_rdata, 32'h5A5A5A5A);
        idle(); cyc();
        chk("stall.data2", r2_rdata, 32'h5A5A5A5A);

        // Out-of-range write and read.
        mwr(16'd4096, 32'hCAFEF00D, 4'hF); cyc();
        chk("oob.wr_flag", r1_oob, 1);
        mrd(16'd4096); cyc();
        chk("oob.rd1", r1_rdata, 0);
        idle(); cyc();
        chk("oob.rd2", r2_rdata, 0);
        cnts("oob", 7, 11);
        mrd(16'h0000); cyc();
        idle(); cyc();
        chk("oob.nowrite1", r1_rdata, 32'h11);
        chk("oob.nowrite2", r2_rdata, 32'h11);
        err_clr = 1; cyc(); err_clr = 0;
        chk("oob.clr1", r1_oob, 0);
        chk("oob.clr2", r2_oob, 0);
        err_clr = 1; mrd(16'hFFFF); cyc(); idle();
        chk("oob.setwins1", r1_oob, 1);
        chk("oob.setwins2", r2_oob, 1);
        err_clr = 1; cyc(); idle();
        ld_valid = 1; ld_addr = 16'h2000; ld_data = 32'h1; cyc(); idle();
        chk("oob.ld", r1_oob, 1);
        cnts("oob2", 9, 12);

        // Reset while a READ_LAT=2 read is in flight.
        mrd(16'h0010); cyc(); idle();
        rst = 1; #1;
        chk("rst2.rdata1", r1_rdata, 0);
        chk("rst2.rdata2", r2_rdata, 0);
        cyc(2);
        rst = 0;
        cyc(3);
        chk("rst2.late2", r2_rdata, 0);
        chk("rst2.oob", r1_oob, 0);
        cnts("rst2", 0, 0);
        mrd(16'h0010); cyc(); idle(); cyc();
        chk("rst2.keep1", r1_rdata, 32'hDEADBEAA);
        chk("rst2.keep2", r2_rdata, 32'hDEADBEAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
